// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback controller.
// Requester indices, register count and default widths.
package regfile_pkg;

  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_DATA_W  = 32;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LSU  = 1;
  localparam int REQ_MDU  = 2;

  localparam int NUM_REGS = 32;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter. Search begins one past ptr and
// wraps; the first active request wins. ptr is owned by the caller.
import regfile_pkg::*;

module rr_arbiter #(
  parameter int N  = DEF_NUM_REQ,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  int idx;

  // Rotating priority scan starting at ptr+1 mod N.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller for the regfile write port.
// - round-robin arbitration among NUM_REQ writeback sources,
//   winner registered onto the write port (one-cycle latency)
// - per-register busy scoreboard with WAW issue stall and rs1/rs2 flags
// Optional macro WB_BYPASS_EN: forward the registered write to rs1/rs2
// and drop the busy flag one cycle earlier.
import regfile_pkg::*;

module regfile_wb_ctrl #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk_i,
  input  logic                      nrst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic                      rd_wren_o,
  output logic [ADDR_W-1:0]         rd_addr_o,
  output logic [DATA_W-1:0]         rd_data_o,
  input  logic                      issue_valid_i,
  input  logic [ADDR_W-1:0]         issue_rd_i,
  output logic                      issue_ready_o,
  input  logic [ADDR_W-1:0]         rs1_addr_i,
  input  logic [ADDR_W-1:0]         rs2_addr_i,
  input  logic [DATA_W-1:0]         rs1_data_i,
  input  logic [DATA_W-1:0]         rs2_data_i,
  output logic [DATA_W-1:0]         rs1_data_o,
  output logic [DATA_W-1:0]         rs2_data_o,
  output logic                      rs1_busy_o,
  output logic                      rs2_busy_o,
  output logic                      wb_orphan_o
);

  localparam int IW = idx_w(NUM_REQ);

  // Packed views of the per-requester address/data buses.
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  assign req_addr = req_addr_i;
  assign req_data = req_data_i;

  // ---------------- arbitration ----------------
  logic [IW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [IW-1:0]      grant_idx;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req         (req_valid_i),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign req_ready_o = grant;

  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  assign win_addr = req_addr[grant_idx];
  assign win_data = req_data[grant_idx];

  // Pointer moves to the winner only on a grant; reset favours index 0.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i)          rr_ptr <= IW'(NUM_REQ - 1);
    else if (grant_valid) rr_ptr <= grant_idx;
  end

  // ---------------- output stage ----------------
  logic              wr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  // Register the winning write; x0 writes are accepted but never enabled.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_q <= grant_valid && (win_addr != '0);
      if (grant_valid) begin
        wr_addr_q <= win_addr;
        wr_data_q <= win_data;
      end
    end
  end

  assign rd_wren_o = wr_q;
  assign rd_addr_o = wr_addr_q;
  assign rd_data_o = wr_data_q;

  // ---------------- scoreboard ----------------
  logic [NUM_REGS-1:0] busy, busy_nxt;
  logic                issue_fire;

  assign issue_ready_o = (issue_rd_i == '0) ? 1'b1 : ~busy[issue_rd_i];
  assign issue_fire    = issue_valid_i && issue_ready_o && (issue_rd_i != '0);

  // Clear on committed write, then set on issue so a set always wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_q)       busy_nxt[wr_addr_q]  = 1'b0;
    if (issue_fire) busy_nxt[issue_rd_i] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Busy bit storage.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) busy <= '0;
    else         busy <= busy_nxt;
  end

  // Orphan: a committed write landed on a register nobody was waiting for.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) wb_orphan_o <= 1'b0;
    else         wb_orphan_o <= wr_q && !busy[wr_addr_q];
  end

  // ---------------- source operand flags ----------------
`ifdef WB_BYPASS_EN
  logic fwd1, fwd2;
  assign fwd1 = wr_q && (wr_addr_q == rs1_addr_i) && (rs1_addr_i != '0);
  assign fwd2 = wr_q && (wr_addr_q == rs2_addr_i) && (rs2_addr_i != '0);

  assign rs1_busy_o = busy[rs1_addr_i] && !fwd1;
  assign rs2_busy_o = busy[rs2_addr_i] && !fwd2;
  assign rs1_data_o = fwd1 ? wr_data_q : rs1_data_i;
  assign rs2_data_o = fwd2 ? wr_data_q : rs2_data_i;
`else
  assign rs1_busy_o = busy[rs1_addr_i];
  assign rs2_busy_o = busy[rs2_addr_i];
  assign rs1_data_o = rs1_data_i;
  assign rs2_data_o = rs2_data_i;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: reset, round-robin order,
// issue/writeback scoreboard, x0, orphan, pointer hold, async reset.
module tb_regfile_wb_ctrl;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             nrst;
  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [2:0][4:0]  req_addr;
  logic [2:0][31:0] req_data;
  logic             rd_wren;
  logic [4:0]       rd_addr;
  logic [31:0]      rd_data;
  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic             issue_ready;
  logic [4:0]       rs1_addr, rs2_addr;
  logic [31:0]      rs1_di, rs2_di, rs1_do, rs2_do;
  logic             rs1_busy, rs2_busy, orphan;

  int checks = 0;
  int failures = 0;

  regfile_wb_ctrl dut (
    .clk_i         (clk),
    .nrst_i        (nrst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_addr_i    (req_addr),
    .req_data_i    (req_data),
    .rd_wren_o     (rd_wren),
    .rd_addr_o     (rd_addr),
    .rd_data_o     (rd_data),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .issue_ready_o (issue_ready),
    .rs1_addr_i    (rs1_addr),
    .rs2_addr_i    (rs2_addr),
    .rs1_data_i    (rs1_di),
    .rs2_data_i    (rs2_di),
    .rs1_data_o    (rs1_do),
    .rs2_data_o    (rs2_do),
    .rs1_busy_o    (rs1_busy),
    .rs2_busy_o    (rs2_busy),
    .wb_orphan_o   (orphan)
  );

  task automatic test_reset();
    nrst = 1'b0;
    req_valid = 3'b111;
    req_addr[0] = 5'd1; req_addr[1] = 5'd2; req_addr[2] = 5'd3;
    req_data[0] = 32'hA0; req_data[1] = 32'hA1; req_data[2] = 32'hA2;
    issue_valid = 1'b1; issue_rd = 5'd4;
    rs1_addr = 5'd4; rs2_addr = 5'd4;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rd_wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%0h exp=0", rd_wren); end
    checks++; if (rd_addr !== 5'd0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", rd_addr); end
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%0h exp=0", rd_data); end
    checks++; if (orphan !== 1'b0) begin failures++; $display("FAIL reset_orphan got=%0h exp=0", orphan); end
    checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h%0h exp=00", rs1_busy, rs2_busy); end
    issue_valid = 1'b0;
    nrst = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL rr_first got=%b exp=001", req_ready); end
    @(negedge clk); #1;
    checks++; if (rd_wren !== 1'b1 || rd_addr !== 5'd1 || rd_data !== 32'hA0) begin failures++; $display("FAIL rr_wb0 got=%0h/%0h/%0h exp=1/1/a0", rd_wren, rd_addr, rd_data); end
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL rr_second got=%b exp=010", req_ready); end
    @(negedge clk); #1;
    checks++; if (rd_addr !== 5'd2 || rd_data !== 32'hA1) begin failures++; $display("FAIL rr_wb1 got=%0h/%0h exp=2/a1", rd_addr, rd_data); end
    checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL rr_third got=%b exp=100", req_ready); end
    checks++; if (orphan !== 1'b1) begin failures++; $display("FAIL rr_orphan_x1 got=%0h exp=1", orphan); end
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    checks++; if (rd_wren !== 1'b1 || rd_addr !== 5'd3 || rd_data !== 32'hA2) begin failures++; $display("FAIL rr_wb2 got=%0h/%0h/%0h exp=1/3/a2", rd_wren, rd_addr, rd_data); end
    @(negedge clk); #1;
    checks++; if (rd_wren !== 1'b0) begin failures++; $display("FAIL idle_wren got=%0h exp=0", rd_wren); end
  endtask

  task automatic test_issue_wb();
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 5'd5;
    #1;
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL issue_x5_ready got=%0h exp=1", issue_ready); end
    @(negedge clk);
    rs1_addr = 5'd5; rs2_addr = 5'd5;
    rs1_di = 32'h1111_1111; rs2_di = 32'h2222_2222;
    req_valid = 3'b001; req_addr[0] = 5'd5; req_data[0] = 32'hDEAD_BEEF;
    #1;
    checks++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin failures++; $display("FAIL busy_x5 got=%0h%0h exp=11", rs1_busy, rs2_busy); end
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL waw_stall got=%0h exp=0", issue_ready); end
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL alu_grant got=%b exp=001", req_ready); end
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    checks++; if (rd_wren !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wb_x5 got=%0h/%0h/%0h exp=1/5/deadbeef", rd_wren, rd_addr, rd_data); end
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL waw_stall_t1 got=%0h exp=0", issue_ready); end
    checks++; if (rs1_busy !== !BYP || rs2_busy !== !BYP) begin failures++; $display("FAIL busy_t1 got=%0h%0h exp=%0h", rs1_busy, rs2_busy, !BYP); end
    checks++; if (rs1_do !== (BYP ? 32'hDEAD_BEEF : 32'h1111_1111)) begin failures++; $display("FAIL rs1_data_t1 got=%0h", rs1_do); end
    checks++; if (rs2_do !== (BYP ? 32'hDEAD_BEEF : 32'h2222_2222)) begin failures++; $display("FAIL rs2_data_t1 got=%0h", rs2_do); end
    @(negedge clk); #1;
    checks++; if (rs1_busy !== 1'b0) begin failures++; $display("FAIL busy_t2 got=%0h exp=0", rs1_busy); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL reissue_ready got=%0h exp=1", issue_ready); end
    checks++; if (orphan !== 1'b0) begin failures++; $display("FAIL x5_not_orphan got=%0h exp=0", orphan); end
    @(negedge clk);
    issue_valid = 1'b0;
    #1;
    checks++; if (rs1_busy !== 1'b1) begin failures++; $display("FAIL reissue_busy got=%0h exp=1", rs1_busy); end
    // retire the second x5 issue
    req_valid = 3'b001; req_data[0] = 32'h0;
    @(negedge clk);
    req_valid = 3'b000;
    @(negedge clk); #1;
    checks++; if (rs1_busy !== 1'b0 || orphan !== 1'b0) begin failures++; $display("FAIL x5_retire got=%0h/%0h exp=0/0", rs1_busy, orphan); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    req_valid = 3'b010; req_addr[1] = 5'd0; req_data[1] = 32'h1234;
    issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0;
    #1;
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL x0_ready got=%b exp=010", req_ready); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL x0_issue got=%0h exp=1", issue_ready); end
    @(negedge clk);
    req_valid = 3'b000; issue_valid = 1'b0;
    #1;
    checks++; if (rd_wren !== 1'b0) begin failures++; $display("FAIL x0_wren got=%0h exp=0", rd_wren); end
    checks++; if (rs1_busy !== 1'b0) begin failures++; $display("FAIL x0_busy got=%0h exp=0", rs1_busy); end
    @(negedge clk); #1;
    checks++; if (orphan !== 1'b0 || rs1_busy !== 1'b0) begin failures++; $display("FAIL x0_orphan got=%0h/%0h exp=0/0", orphan, rs1_busy); end
  endtask

  task automatic test_orphan();
    @(negedge clk);
    req_valid = 3'b100; req_addr[2] = 5'd7; req_data[2] = 32'h55;
    #1;
    checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL mdu_ready got=%b exp=100", req_ready); end
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    checks++; if (rd_wren !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'h55) begin failures++; $display("FAIL mdu_wb got=%0h/%0h/%0h exp=1/7/55", rd_wren, rd_addr, rd_data); end
    checks++; if (orphan !== 1'b0) begin failures++; $display("FAIL orphan_early got=%0h exp=0", orphan); end
    @(negedge clk); #1;
    checks++; if (orphan !== 1'b1 || rd_wren !== 1'b0) begin failures++; $display("FAIL orphan_pulse got=%0h/%0h exp=1/0", orphan, rd_wren); end
    @(negedge clk); #1;
    checks++; if (orphan !== 1'b0) begin failures++; $display("FAIL orphan_end got=%0h exp=0", orphan); end
  endtask

  task automatic test_rr_ptr();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 3'b010; req_addr[1] = 5'd9; req_data[1] = 32'(i);
      #1;
      checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL lsu_only_%0d got=%b exp=010", i, req_ready); end
    end
    @(negedge clk);
    req_valid = 3'b011; req_addr[0] = 5'd10;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL ptr1_grant got=%b exp=001", req_ready); end
    @(negedge clk); #1;
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL ptr0_grant got=%b exp=010", req_ready); end
    @(negedge clk);
    req_valid = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 5'd12;
    req_valid = 3'b100; req_addr[2] = 5'd13; req_data[2] = 32'hAA;
    @(negedge clk);
    issue_valid = 1'b0; req_valid = 3'b000; rs1_addr = 5'd12;
    #1;
    checks++; if (rd_wren !== 1'b1 || rs1_busy !== 1'b1) begin failures++; $display("FAIL pre_reset got=%0h/%0h exp=1/1", rd_wren, rs1_busy); end
    #1 nrst = 1'b0;
    #1;
    checks++; if (rd_wren !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'd0) begin failures++; $display("FAIL async_wb got=%0h/%0h/%0h exp=0/0/0", rd_wren, rd_addr, rd_data); end
    checks++; if (rs1_busy !== 1'b0) begin failures++; $display("FAIL async_busy got=%0h exp=0", rs1_busy); end
    @(negedge clk);
    nrst = 1'b1;
    req_valid = 3'b111;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL ptr_after_reset got=%b exp=001", req_ready); end
    req_valid = 3'b000;
    @(negedge clk);
  endtask

  initial begin
    nrst = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    rs1_addr = '0; rs2_addr = '0; rs1_di = '0; rs2_di = '0;
    test_reset();
    test_issue_wb();
    test_x0();
    test_orphan();
    test_rr_ptr();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
